// File: rtl/rv32_pkg.sv
// Shared fetch-stage state encoding, PC step and address helpers.
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        KILL  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Fetch program counter: 32-bit register with load enable and
// synchronous active-low reset to the boot address.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    // PC storage, loaded only when enabled
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else if (en_i) begin
            pc_q <= d_i;
        end else begin
            pc_q <= pc_q;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect/kill handling.
// All outputs come straight from registers; inputs never reach outputs combinationally.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_err
);

    fetch_state_e state_q;
    logic         imem_req_q;
    logic [31:0]  imem_addr_q;
    logic         instr_valid_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    logic         fetch_err_q;

    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic         pc_en_d;
    logic [31:0]  pc_next_d;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i  (clock),
        .rst_ni (reset),
        .en_i   (pc_en_d),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    // PC next value: redirect target beats the sequential step of an accepted fetch
    always_comb begin
        pc_en_d   = 1'b0;
        pc_d      = pc_q + PC_STEP;
        pc_next_d = pc_q;
        if (redirect_valid) begin
            pc_en_d = 1'b1;
            pc_d    = align_word(redirect_pc);
        end else if ((state_q == REQ) && imem_ack) begin
            pc_en_d = 1'b1;
        end else begin
            pc_en_d = 1'b0;
        end
        pc_next_d = pc_en_d ? pc_d : pc_q;
    end

    // Fetch FSM with registered request and instruction outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            fetch_err_q   <= 1'b0;
        end else begin
            fetch_err_q <= redirect_valid && is_misaligned(redirect_pc);
            case (state_q)
                IDLE: begin
                    state_q       <= REQ;
                    imem_req_q    <= 1'b1;
                    imem_addr_q   <= pc_next_d;
                    instr_valid_q <= 1'b0;
                end
                REQ: begin
                    if (redirect_valid) begin
                        instr_valid_q <= 1'b0;
                        imem_req_q    <= 1'b1;
                        if (imem_ack) begin
                            state_q     <= REQ;
                            imem_addr_q <= pc_next_d;
                        end else begin
                            // bus request must stay stable until the stale word returns
                            state_q     <= KILL;
                            imem_addr_q <= imem_addr_q;
                        end
                    end else if (imem_ack) begin
                        state_q       <= VALID;
                        imem_req_q    <= 1'b0;
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                    end else begin
                        state_q    <= REQ;
                        imem_req_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (redirect_valid || !stall) begin
                        state_q       <= REQ;
                        imem_req_q    <= 1'b1;
                        imem_addr_q   <= pc_next_d;
                        instr_valid_q <= 1'b0;
                    end else begin
                        state_q       <= VALID;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                KILL: begin
                    instr_valid_q <= 1'b0;
                    imem_req_q    <= 1'b1;
                    if (imem_ack) begin
                        state_q     <= REQ;
                        imem_addr_q <= pc_next_d;
                    end else begin
                        state_q     <= KILL;
                        imem_addr_q <= imem_addr_q;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a transaction-level reference model;
// instance 1 boots at 32'hFFFF_FFFC to exercise PC wrap.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        req_w   [2];
    logic [31:0] addr_w  [2];
    logic        valid_w [2];
    logic [31:0] instr_w [2];
    logic [31:0] ipc_w   [2];
    logic        err_w   [2];

    int n_total;
    int n_bad;

    // reference model: outstanding request, pending drop, held instruction
    logic [31:0] m_rst_pc [2];
    logic [31:0] m_pc     [2];
    logic        m_out    [2];
    logic        m_drop   [2];
    logic [31:0] m_addr   [2];
    logic        m_have   [2];
    logic [31:0] m_instr  [2];
    logic [31:0] m_ipc    [2];
    logic        m_err    [2];

    logic        r_rst, r_st, r_rv, r_ack;
    logic [31:0] r_rpc;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(req_w[0]), .imem_addr(addr_w[0]),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(valid_w[0]), .instr(instr_w[0]), .instr_pc(ipc_w[0]),
        .fetch_err(err_w[0])
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(req_w[1]), .imem_addr(addr_w[1]),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(valid_w[1]), .instr(instr_w[1]), .instr_pc(ipc_w[1]),
        .fetch_err(err_w[1])
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input logic rst_v, input logic st_v, input logic rv_v,
                              input logic [31:0] rpc_v, input logic ack_v, input logic [31:0] rd_v);
        logic fin;
        if (!rst_v) begin
            m_pc[i]    = m_rst_pc[i];
            m_out[i]   = 1'b0;
            m_drop[i]  = 1'b0;
            m_have[i]  = 1'b0;
            m_instr[i] = 32'd0;
            m_ipc[i]   = 32'd0;
            m_err[i]   = 1'b0;
        end else begin
            fin      = m_out[i] && ack_v;
            m_err[i] = rv_v && ((rpc_v % 32'd4) != 32'd0);
            if (fin && !m_drop[i] && !rv_v) begin
                m_have[i]  = 1'b1;
                m_instr[i] = rd_v;
                m_ipc[i]   = m_addr[i];
                m_pc[i]    = m_addr[i] + 32'd4;
            end else if (m_have[i] && (!st_v || rv_v)) begin
                m_have[i] = 1'b0;
            end
            if (rv_v) m_pc[i] = rpc_v - (rpc_v % 32'd4);
            if (fin) begin
                m_out[i]  = 1'b0;
                m_drop[i] = 1'b0;
            end else if (m_out[i] && rv_v) begin
                m_drop[i] = 1'b1;
            end
            if (!m_out[i] && !m_have[i]) begin
                m_out[i]  = 1'b1;
                m_addr[i] = m_pc[i];
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("m_req%0d", i), 32'(req_w[i]), 32'(m_out[i]));
            if (m_out[i]) check_eq($sformatf("m_addr%0d", i), addr_w[i], m_addr[i]);
            check_eq($sformatf("m_valid%0d", i), 32'(valid_w[i]), 32'(m_have[i]));
            check_eq($sformatf("m_instr%0d", i), instr_w[i], m_instr[i]);
            check_eq($sformatf("m_ipc%0d", i), ipc_w[i], m_ipc[i]);
            check_eq($sformatf("m_err%0d", i), 32'(err_w[i]), 32'(m_err[i]));
        end
    endtask

    // drive at negedge, model updates at posedge, compare at next negedge
    task automatic step(input logic rst_v, input logic st_v, input logic rv_v,
                        input logic [31:0] rpc_v, input logic ack_v, input logic [31:0] rd_v);
        reset          = rst_v;
        stall          = st_v;
        redirect_valid = rv_v;
        redirect_pc    = rpc_v;
        imem_ack       = ack_v;
        imem_rdata     = rd_v;
        @(posedge clock);
        for (int i = 0; i < 2; i++) model_step(i, rst_v, st_v, rv_v, rpc_v, ack_v, rd_v);
        @(negedge clock);
        check_all();
    endtask

    initial begin
        clock = 1'b0;
        n_total = 0;
        n_bad = 0;
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
        m_rst_pc[0] = 32'h0000_0000;
        m_rst_pc[1] = 32'hFFFF_FFFC;
        for (int i = 0; i < 2; i++) m_addr[i] = 32'd0;
        @(negedge clock);

        // reset overrides a simultaneous redirect and ack
        step(1'b0, 1'b0, 1'b1, 32'h0000_0042, 1'b1, 32'h1111_1111);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("rst_req", 32'(req_w[0]), 32'd0);
        check_eq("rst_valid", 32'(valid_w[0]), 32'd0);
        check_eq("rst_instr", instr_w[0], 32'd0);
        check_eq("rst_ipc", ipc_w[0], 32'd0);
        check_eq("rst_err", 32'(err_w[0]), 32'd0);

        // release, then ack every request with no stall
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int k = 0; k < 6; k++) begin
            if ((k % 2) == 0) begin
                check_eq("seq_req", 32'(req_w[0]), 32'd1);
                check_eq("seq_addr", addr_w[0], 32'(2 * k));
                check_eq("wrap_addr", addr_w[1], 32'hFFFF_FFFC + 32'(2 * k));
            end else begin
                check_eq("seq_valid", 32'(valid_w[0]), 32'd1);
                check_eq("seq_ipc", ipc_w[0], 32'(2 * (k - 1)));
                check_eq("wrap_ipc", ipc_w[1], 32'hFFFF_FFFC + 32'(2 * (k - 1)));
            end
            step(1'b1, 1'b0, 1'b0, 32'd0, m_out[0], $urandom);
        end

        // capture a NOP and stall on it for five cycles
        step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0000_0013);
        for (int k = 0; k < 5; k++) begin
            check_eq("stall_instr", instr_w[0], 32'h0000_0013);
            check_eq("stall_ipc", ipc_w[0], 32'h0000_000C);
            check_eq("stall_valid", 32'(valid_w[0]), 32'd1);
            check_eq("stall_req", 32'(req_w[0]), 32'd0);
            step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, $urandom);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("cons_req", 32'(req_w[0]), 32'd1);
        check_eq("cons_addr", addr_w[0], 32'h0000_0010);

        // redirect during an outstanding request, ack arrives late
        step(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check_eq("kill_req", 32'(req_w[0]), 32'd1);
            check_eq("kill_addr", addr_w[0], 32'h0000_0010);
            check_eq("kill_valid", 32'(valid_w[0]), 32'd0);
            step(1'b1, 1'b0, 1'b0, 32'd0, (k == 2), 32'hDEAD_BEEF);
        end
        check_eq("kill_valid_after", 32'(valid_w[0]), 32'd0);
        check_eq("kill_new_addr", addr_w[0], 32'h0000_0100);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0BAD_F00D);
        check_eq("tgt_ipc", ipc_w[0], 32'h0000_0100);
        check_eq("tgt_instr", instr_w[0], 32'h0BAD_F00D);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // misaligned redirect coinciding with an ack
        step(1'b1, 1'b0, 1'b1, 32'h0000_0102, 1'b1, 32'h5555_5555);
        check_eq("err_pulse", 32'(err_w[0]), 32'd1);
        check_eq("err_addr", addr_w[0], 32'h0000_0100);
        check_eq("err_valid", 32'(valid_w[0]), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("err_clear", 32'(err_w[0]), 32'd0);

        // reset mid-request, stray ack while idle
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h7777_7777);
        check_eq("midrst_req", 32'(req_w[0]), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h7777_7777);
        check_eq("idle_ack_valid", 32'(valid_w[0]), 32'd0);
        check_eq("post_rst_addr0", addr_w[0], 32'h0000_0000);
        check_eq("post_rst_addr1", addr_w[1], 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check_eq("idle_ack_valid2", 32'(valid_w[0]), 32'd0);

        // randomised traffic
        for (int n = 0; n < 4000; n++) begin
            r_rst = ($urandom_range(0, 149) != 0);
            r_st  = ($urandom_range(0, 2) == 0);
            r_rv  = ($urandom_range(0, 7) == 0);
            r_rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
            r_ack = m_out[0] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            step(r_rst, r_st, r_rv, r_rpc, r_ack, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 stall  input  1  downstream not ready; the held instruction is not consumed.
REQ-005 redirect_valid  input  1  branch/jump taken; replace fetch PC this cycle.
REQ-006 redirect_pc  input  32  target address for redirect.
REQ-007 imem_req  output  1  instruction memory request, held high until imem_ack.
REQ-008 imem_addr  output  32  word-aligned fetch address, stable while imem_req high.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle, completing the request.
REQ-010 imem_rdata  input  32  instruction word from memory.
REQ-011 instr_valid  output  1  instr/instr_pc hold a fetched, unconsumed instruction.
REQ-012 instr  output  32  fetched instruction; feeds the 32-bit enabled pipeline register.
REQ-013 instr_pc  output  32  address of instr.
REQ-014 fetch_err  output  1  one-cycle pulse: misaligned redirect_pc received.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, VALID, KILL; at most one memory request outstanding.
REQ-016 IDLE: imem_req=0; unconditionally to REQ next cycle (first imem_req one cycle after reset release).
REQ-017 REQ: imem_req=1, imem_addr=pc; on imem_ack: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, go VALID.
REQ-018 VALID: a consumption occurs on a cycle with instr_valid=1 and stall=0; then instr_valid<=0 and go REQ (next imem_req one cycle after consumption).
REQ-019 VALID with stall=1: instr, instr_pc, instr_valid, pc SHALL hold; imem_req=0.
REQ-020 Redirect has priority over all other events: pc<={redirect_pc[31:2],2'b00}, instr_valid<=0 next cycle.
REQ-021 Redirect in IDLE or VALID: go REQ; next imem_addr equals aligned redirect target.
REQ-022 Redirect in REQ without imem_ack: go KILL; imem_req and imem_addr SHALL remain unchanged until ack.
REQ-023 KILL: on imem_ack discard imem_rdata, go REQ with redirected pc; instr_valid stays 0.
REQ-024 Redirect in REQ with imem_ack same cycle: returned data discarded, go REQ with redirected pc.
REQ-025 Redirect in KILL: pc updated to newest target, remain KILL.
REQ-026 Redirect and consumption in same cycle in VALID: redirect wins, consumption still counts (instruction leaves).
REQ-027 fetch_err SHALL pulse one cycle after any redirect with redirect_pc[1:0]!=0; 0 otherwise.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

Reset
REQ-029 With reset=0 at a rising edge: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fetch_err=0.
REQ-030 Reset asserted mid-request SHALL abandon it; any later imem_ack while IDLE SHALL be ignored.
REQ-031 Reset SHALL override redirect_valid and imem_ack in the same cycle.

Structure
REQ-032 State encoding (2 bits: IDLE=0, REQ=1, VALID=2, KILL=3) and PC_STEP=4 SHALL live in shared package rv32_pkg.
REQ-033 The PC SHALL be a sub-module pc_reg: 32-bit, enable, synchronous active-low reset to RESET_PC.
REQ-034 Output datapath registers SHALL be registered; imem_req/imem_addr SHALL be decoded from state and pc only (no input-to-output combinational path).

Verification
REQ-035 Reset release, ack every cycle, stall=0 -> imem_addr 0,4,8; instr_valid every other cycle with instr_pc 0,4,8.
REQ-036 stall=1 for 5 cycles in VALID with instr=32'h0000_0013 -> instr, instr_pc, instr_valid constant; imem_req=0.
REQ-037 Redirect to 32'h0000_0100 while REQ, ack delayed 3 cycles -> imem_addr held until ack, data dropped, next imem_addr=32'h100, instr_valid never 1 for dropped word.
REQ-038 Redirect to 32'h0000_0102 -> fetch_err one cycle, next imem_addr=32'h100.
REQ-039 RESET_PC=32'hFFFF_FFFC, two fetches -> instr_pc FFFF_FFFC then 0000_0000.
REQ-040 reset=0 during REQ then ack arrives in IDLE -> instr_valid stays 0; first post-reset imem_addr=RESET_PC.
